// File: rtl/arb_egress_pkg.sv
// Shared types and helpers for the arbiter egress buffer.
package arb_egress_pkg;

  // Occupancy of the two-entry egress buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Requestor id width; a single requestor still carries a 1-bit id
  function automatic int idwid(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default configuration, also used to size the stored entry type
  localparam int DEF_NUM_REQS = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_IDWID    = idwid(DEF_NUM_REQS);

  // One buffered packet: requestor id plus payload
  typedef struct packed {
    logic [DEF_IDWID-1:0] id;
    logic [DEF_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/arb_egress_buffer_if.sv
// Arbiter-side and sink-side signals of the egress buffer.
// master = arbiter/FIFOs/sink environment, slave = the buffer.
interface arb_egress_buffer_if
  import arb_egress_pkg::*;
#(
  parameter int NUM_REQS = DEF_NUM_REQS,
  parameter int WIDTH    = DEF_WIDTH
);
  localparam int IDWID = idwid(NUM_REQS);

  logic [NUM_REQS-1:0]       gnt;
  logic [NUM_REQS*WIDTH-1:0] flat_data_out;
  logic                      blk;
  logic                      out_vld;
  logic                      out_rdy;
  logic [WIDTH-1:0]          out_data;
  logic [IDWID-1:0]          out_id;
  logic                      gnt_err;

  modport master (
    output gnt, flat_data_out, out_rdy,
    input  blk, out_vld, out_data, out_id, gnt_err
  );

  modport slave (
    input  gnt, flat_data_out, out_rdy,
    output blk, out_vld, out_data, out_id, gnt_err
  );
endinterface

// File: rtl/arb_egress_buffer_ff.sv
// Shared register primitive: sync active-high reset to zero, load enable.
module arb_egress_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Reset wins; otherwise load when enabled
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/arb_egress_ohe.sv
// Grant encoder: lowest set bit wins, plus multi-hot detection.
module arb_egress_ohe
  import arb_egress_pkg::*;
#(
  parameter int N  = DEF_NUM_REQS,
  parameter int IW = idwid(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          multi
);
  // Scan high to low so the lowest set bit is the last assignment
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
  end

  assign any   = |req;
  // Clearing the lowest set bit leaves something only if 2+ bits were set
  assign multi = |(req & (req - N'(1)));
endmodule

// File: rtl/arb_egress_buffer.sv
// Egress buffer behind the DWRR arbiter: captures the granted FIFO head,
// tags it with the requestor id, and holds up to two packets in order.
// blk is raised while both entries are occupied.
// Optional per-requestor departure counters: define ARB_EGRESS_STATS_EN.
module arb_egress_buffer
  import arb_egress_pkg::*;
#(
  parameter int NUM_REQS = DEF_NUM_REQS,
  parameter int WIDTH    = DEF_WIDTH
`ifdef ARB_EGRESS_STATS_EN
  , parameter int STWID  = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  arb_egress_buffer_if.slave        bus
`ifdef ARB_EGRESS_STATS_EN
  , output logic [NUM_REQS*STWID-1:0] stats_flat
`endif
);
  localparam int IDWID = idwid(NUM_REQS);

  typedef struct packed {
    logic [IDWID-1:0] id;
    logic [WIDTH-1:0] data;
  } ent_t;
  localparam int EW = $bits(ent_t);

  state_t           state;
  logic             blk_q, vld_q, err_q;
  logic             wr_ptr, rd_ptr;
  logic [IDWID-1:0] idx;
  logic             any, multi;
  logic             cap, pop;
  ent_t             wr_ent, head;
  ent_t [1:0]       ent_q;

  arb_egress_ohe #(.N(NUM_REQS), .IW(IDWID)) u_ohe (
    .req(bus.gnt), .idx(idx), .any(any), .multi(multi)
  );

  // Grants are only honoured while not blocking; pops need a valid head
  assign cap    = any & ~blk_q;
  assign pop    = vld_q & bus.out_rdy;
  assign wr_ent = '{id: idx, data: bus.flat_data_out[idx*WIDTH +: WIDTH]};

  for (genvar e = 0; e < 2; e++) begin : g_ent
    arb_egress_ff #(.W(EW)) u_ent (
      .clk(clk), .rst(rst), .en(cap & (wr_ptr == 1'(e))),
      .d(wr_ent), .q(ent_q[e])
    );
  end

  arb_egress_ff #(.W(1)) u_wr (.clk(clk), .rst(rst), .en(cap), .d(~wr_ptr), .q(wr_ptr));
  arb_egress_ff #(.W(1)) u_rd (.clk(clk), .rst(rst), .en(pop), .d(~rd_ptr), .q(rd_ptr));

  // Sticky: dropped grant while blocked, or more than one grant bit
  arb_egress_ff #(.W(1)) u_err (
    .clk(clk), .rst(rst), .en(1'b1),
    .d(err_q | (any & blk_q) | multi), .q(err_q)
  );

  // Occupancy FSM; blk and out_vld are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      blk_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: if (cap) begin
          state <= ONE;
          vld_q <= 1'b1;
        end
        ONE: begin
          if (cap && !pop) begin
            state <= FULL;
            blk_q <= 1'b1;
          end else if (pop && !cap) begin
            state <= EMPTY;
            vld_q <= 1'b0;
          end
        end
        FULL: if (pop) begin
          state <= ONE;
          blk_q <= 1'b0;
        end
        default: begin
          state <= EMPTY;
          blk_q <= 1'b0;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  // Stale entries stay in storage, so mask the head when nothing is valid
  assign head         = ent_q[rd_ptr];
  assign bus.blk      = blk_q;
  assign bus.out_vld  = vld_q;
  assign bus.out_data = vld_q ? head.data : '0;
  assign bus.out_id   = vld_q ? head.id : '0;
  assign bus.gnt_err  = err_q;

`ifdef ARB_EGRESS_STATS_EN
  for (genvar r = 0; r < NUM_REQS; r++) begin : g_stat
    logic [STWID-1:0] cnt_q;
    arb_egress_ff #(.W(STWID)) u_cnt (
      .clk(clk), .rst(rst), .en(pop & (head.id == IDWID'(r))),
      .d(cnt_q + STWID'(1)), .q(cnt_q)
    );
    assign stats_flat[r*STWID +: STWID] = cnt_q;
  end
`endif
endmodule
